// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forward selects,
// sequencing states and the register-dependency helper.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic regHit(input logic [4:0] rs, input logic [4:0] rd, input logic we);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_forward.sv
// Execute-stage operand forwarding select for a single source operand.
module hazard_forward
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_o
);

    // The memory stage holds the younger result, so it wins over writeback.
    always_comb begin
        fwd_o = FWD_REG;
        if (regHit(rs_e_i, rd_m_i, reg_write_m_i)) begin
            fwd_o = FWD_MEM;
        end else if (regHit(rs_e_i, rd_w_i, reg_write_w_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward sequencing for the five-stage core, with memory-wait FSM
// and saturating statistics. Optional macro: HAZARD_FORWARDING_EN.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RD_E,
    input  logic             RegWriteE,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RD_M,
    input  logic             RegWriteM,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q;
    logic [WCW-1:0]   waitCnt_q;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
    logic             memHold;
    logic             loadUse;
    logic             decodeHazard;
    logic [1:0]       fwdA, fwdB;

    assign loadUse = ResultSrcE && (RD_E != 5'd0) && ((RD_E == Rs1D) || (RD_E == Rs2D));

`ifdef HAZARD_FORWARDING_EN
    logic unusedRegWriteE;
    assign unusedRegWriteE = RegWriteE;

    hazard_forward u_fwd_a (
        .rs_e_i        (Rs1E),
        .rd_m_i        (RD_M),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RD_W),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwdA)
    );

    hazard_forward u_fwd_b (
        .rs_e_i        (Rs2E),
        .rd_m_i        (RD_M),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RD_W),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwdB)
    );

    assign decodeHazard = loadUse;
`else
    // Without bypass paths every in-flight writer of a decode source must drain.
    logic unusedRsE;
    assign unusedRsE = ^{Rs1E, Rs2E};
    assign fwdA = FWD_REG;
    assign fwdB = FWD_REG;
    assign decodeHazard = loadUse
        || regHit(Rs1D, RD_E, RegWriteE) || regHit(Rs2D, RD_E, RegWriteE)
        || regHit(Rs1D, RD_M, RegWriteM) || regHit(Rs2D, RD_M, RegWriteM)
        || regHit(Rs1D, RD_W, RegWriteW) || regHit(Rs2D, RD_W, RegWriteW);
`endif

    assign memHold = ((state_q == RUN) && MemReqM && !MemReadyM)
                  || ((state_q == WAIT) && !MemReadyM)
                  || (state_q == ERR);

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (memHold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (decodeHazard) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign ForwardAE = rst ? FWD_REG : fwdA;
    assign ForwardBE = rst ? FWD_REG : fwdB;
    assign MemErr    = (state_q == ERR) && !rst;

    assign stallCnt_d = (StallF && !(&stallCnt_q)) ? stallCnt_q + CNT_W'(1) : stallCnt_q;
    assign flushCnt_d = (FlushE && !(&flushCnt_q)) ? flushCnt_q + CNT_W'(1) : flushCnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            waitCnt_q  <= '0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
            case (state_q)
                RUN: begin
                    waitCnt_q <= '0;
                    if (MemReqM && !MemReadyM) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    waitCnt_q <= waitCnt_q + WCW'(1);
                    if (MemReadyM) begin
                        state_q <= RUN;
                    end else if (waitCnt_q == WCW'(MEM_TIMEOUT - 1)) begin
                        state_q <= ERR;
                    end
                end
                ERR:     state_q <= ERR;
                default: state_q <= RUN;
            endcase
        end
    end

    assign StallCnt = stallCnt_q;
    assign FlushCnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed vectors push expected
// outputs, a negedge monitor pops and compares.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RD_W;
    logic       RegWriteE, ResultSrcE, PCSrcE;
    logic       RegWriteM, MemReqM, MemReadyM, RegWriteW;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MemErr;
    logic [3:0] StallCnt, FlushCnt;

    typedef struct packed {
        logic [3:0] stall;
        logic [2:0] flush;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       err;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

`ifdef HAZARD_FORWARDING_EN
    localparam logic [1:0] FM = 2'b10;
    localparam logic [1:0] FW = 2'b01;
    localparam logic [3:0] RAW_STALL = 4'b0000;
    localparam logic [2:0] RAW_FLUSH = 3'b000;
`else
    localparam logic [1:0] FM = 2'b00;
    localparam logic [1:0] FW = 2'b00;
    localparam logic [3:0] RAW_STALL = 4'b1100;
    localparam logic [2:0] RAW_FLUSH = 3'b010;
`endif

    exp_t       expQ[$];
    string      nameQ[$];
    logic [3:0] scModel = 4'd0;
    logic [3:0] fcModel = 4'd0;
    int         checks = 0;
    int         errors = 0;

    hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RD_E(RD_E),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RD_M(RD_M), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .RD_W(RD_W), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0;
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RD_E = 5'd0; RD_M = 5'd0; RD_W = 5'd0;
        RegWriteE = 1'b0; ResultSrcE = 1'b0; PCSrcE = 1'b0;
        RegWriteM = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0; RegWriteW = 1'b0;
    endtask

    // Counter expectations follow the expected StallF/FlushE of each cycle.
    task automatic applyStimulus(input string name, input logic [3:0] stall, input logic [2:0] flush,
                                 input logic [1:0] fa, input logic [1:0] fb, input logic err);
        exp_t e;
        e = '{stall: stall, flush: flush, fa: fa, fb: fb, err: err, sc: scModel, fc: fcModel};
        expQ.push_back(e);
        nameQ.push_back(name);
        if (rst) begin
            scModel = 4'd0;
            fcModel = 4'd0;
        end else begin
            if (stall[3] && scModel != 4'hF) scModel = scModel + 4'd1;
            if (flush[1] && fcModel != 4'hF) fcModel = fcModel + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        exp_t a;
        a = '{stall: {StallF, StallD, StallE, StallM}, flush: {FlushD, FlushE, FlushW},
              fa: ForwardAE, fb: ForwardBE, err: MemErr, sc: StallCnt, fc: FlushCnt};
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s: got stall=%b flush=%b fa=%b fb=%b err=%b sc=%0d fc=%0d, want stall=%b flush=%b fa=%b fb=%b err=%b sc=%0d fc=%0d",
                     name, a.stall, a.flush, a.fa, a.fb, a.err, a.sc, a.fc,
                     e.stall, e.flush, e.fa, e.fb, e.err, e.sc, e.fc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(nameQ.pop_front(), expQ.pop_front());
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;

        idle(); rst = 1'b1;
        applyStimulus("reset", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
        idle();
        applyStimulus("idle", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        idle();
        RD_M = 5'd5; RegWriteM = 1'b1; RD_W = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd5;
        applyStimulus("fwd mem", 4'b0000, 3'b000, FM, FM, 1'b0);
        RegWriteM = 1'b0;
        applyStimulus("fwd wb", 4'b0000, 3'b000, FW, FW, 1'b0);
        RD_M = 5'd0; RegWriteM = 1'b1; Rs1E = 5'd0;
        applyStimulus("fwd x0", 4'b0000, 3'b000, 2'b00, FW, 1'b0);

        idle();
        ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd5; Rs2D = 5'd5;
        applyStimulus("load-use", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        idle();
        applyStimulus("after load-use", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        idle();
        ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd0;
        applyStimulus("load to x0", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        idle();
        PCSrcE = 1'b1; ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd5; Rs2D = 5'd5;
        applyStimulus("branch over load-use", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);

        idle();
        MemReqM = 1'b1; MemReadyM = 1'b1;
        applyStimulus("mem ready first", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        idle();
        MemReqM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            PCSrcE = (i == 1);
            applyStimulus("mem wait", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        end
        PCSrcE = 1'b0; MemReadyM = 1'b1;
        applyStimulus("mem release", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        idle();
        applyStimulus("after mem", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        idle();
        MemReqM = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus("mem timeout pending", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        end
        MemReadyM = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus("err frozen", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1);
        end
        idle(); rst = 1'b1;
        applyStimulus("reset from err", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
        idle();
        applyStimulus("after reset", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        idle();
        RD_M = 5'd3; RegWriteM = 1'b1; Rs1D = 5'd3;
        applyStimulus("raw dep on mem", RAW_STALL, RAW_FLUSH, 2'b00, 2'b00, 1'b0);
        RegWriteM = 1'b0;
        applyStimulus("no write no dep", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        idle();
        ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd7; Rs1D = 5'd7;
        for (int i = 0; i < 17; i++) begin
            applyStimulus("saturate", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        end
        idle();
        applyStimulus("saturated", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expected entries left, want 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the five-stage RISC-V core. It sits beside the fetch, decode, execute, memory and writeback cycle modules and drives the stall and flush enables of their pipeline registers. It also generates the execute-stage operand forwarding selects and holds the pipeline for variable-latency data memory. It keeps hazard statistics counters for performance bring-up.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for one data-memory access before error.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in decode.
- Rs1E, Rs2E, RD_E  in  5 each  source and destination registers in execute.
- RegWriteE, ResultSrcE, PCSrcE  in  1 each  execute write enable, load flag, branch/jump taken.
- RD_M  in  5; RegWriteM, MemReqM, MemReadyM  in  1 each  memory-stage destination, write enable, access request, memory ready.
- RD_W  in  5; RegWriteW  in  1  writeback destination and write enable.
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1 each  load a bubble into the corresponding pipeline register.
- ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 10 ALUResultM, 01 ResultW.
- MemErr  out  1  sticky memory-timeout error.
- StallCnt, FlushCnt  out  CNT_W each  saturating event counters.

## Operation
- The block has one clock, clk. Reset rst is synchronous and active-high.
- FSM states:
  - RUN: normal operation.
  - WAIT: a data-memory access is outstanding.
  - ERR: memory timeout; the pipeline stays frozen.
- RUN → WAIT when MemReqM && !MemReadyM.
- WAIT → RUN when MemReadyM.
- In WAIT, wait_cnt increments each cycle. WAIT → ERR when wait_cnt == MEM_TIMEOUT-1 and !MemReadyM.
- ERR is left only by rst.
- Memory hold condition: (RUN && MemReqM && !MemReadyM) || WAIT-without-MemReadyM || ERR.
  - Effect: StallF = StallD = StallE = StallM = 1 and FlushW = 1.
  - This condition has highest priority; PCSrcE and load-use are ignored while it holds.
- Branch (PCSrcE, no memory hold): FlushD = FlushE = 1, no stall.
  - Branch wins over a simultaneous load-use, because the decode instruction is on the wrong path.
- Load-use (no memory hold, no branch): ResultSrcE && RD_E != 0 && (RD_E == Rs1D || RD_E == Rs2D).
  - Effect: StallF = StallD = 1 and FlushE = 1.
- Forwarding for operand A (operand B is symmetric with Rs2E):
  - 10 if RegWriteM && RD_M != 0 && RD_M == Rs1E;
  - else 01 if RegWriteW && RD_W != 0 && RD_W == Rs1E;
  - else 00.
- StallCnt increments on every cycle with StallF = 1.
- FlushCnt increments on every cycle with FlushE = 1.
- Both counters saturate at all-ones.
- MemErr = 1 exactly while in ERR.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the current state, so they take effect in the same cycle.
- State, wait_cnt and the counters update on the rising edge of clk.
- While rst is high:
  - FlushD = FlushE = 1;
  - all stalls = 0, FlushW = 0;
  - forwards = 00, MemErr = 0.
- On the first edge with rst high, the state becomes RUN and wait_cnt and both counters become 0.
- rst asserted in WAIT or ERR returns to RUN on the next edge; the outstanding access is abandoned.
- A memory access ready in its first cycle (MemReqM && MemReadyM) causes zero stall cycles and no FSM transition.
- A load-use hazard costs exactly one bubble. A taken branch costs two flushed slots.
- A wait of exactly MEM_TIMEOUT-1 cycles followed by ready does not raise an error.

## Configuration
- HAZARD_FORWARDING_EN defined: the forwarding logic is present as described above.
- HAZARD_FORWARDING_EN undefined:
  - ForwardAE and ForwardBE are tied to 00.
  - Any Rs1D or Rs2D (nonzero) matching RD_E (with RegWriteE), RD_M (with RegWriteM) or RD_W (with RegWriteW) is treated as load-use: StallF = StallD = 1, FlushE = 1.
  - Memory hold and branch priorities are unchanged.

## Structure
- The shared package hazard_pkg holds:
  - the forward-select constants FWD_REG, FWD_MEM, FWD_WB;
  - the FSM state enum (RUN, WAIT, ERR).
- One sub-module, hazard_forward, holds the comparator and priority logic for one operand and is instantiated twice.

## Test plan
- Forwarding: RD_M = 5, RegWriteM = 1, RD_W = 5, RegWriteW = 1, Rs1E = 5 → ForwardAE = 10. Then RegWriteM = 0 → ForwardAE = 01. RD_M = 0 with Rs1E = 0 → 00.
- Load-use: ResultSrcE = 1, RD_E = 5, Rs2D = 5 → StallF = StallD = FlushE = 1 for one cycle; StallCnt = 1, FlushCnt = 1.
- Branch plus load-use in the same cycle: PCSrcE = 1 → FlushD = FlushE = 1, StallF = 0.
- Memory wait: MemReqM = 1, MemReadyM = 0 for 3 cycles, then 1 → all stalls and FlushW high for 3 cycles, then released; MemErr = 0.
- Timeout: MemReadyM held low with MEM_TIMEOUT = 4 → ERR reached, MemErr = 1 and stalls stay high. rst for 1 cycle → RUN, counters 0, MemErr = 0.
- Without HAZARD_FORWARDING_EN: RD_M = 3, RegWriteM = 1, Rs1D = 3 → StallF = 1, ForwardAE = 00.
